// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage-tagged stall requests, sequences multi-cycle
// flushes with a redirect PC, and watches for stall lock-up.
module pipe_ctrl #(
  parameter int                   NUM_STAGES = 5,
  parameter int                   NUM_REQ    = 2,
  parameter logic [NUM_REQ*3-1:0] REQ_STAGE  = {3'd3, 3'd2},
  parameter int                   FLUSH_CYC  = 2,
  parameter int                   WDOG_W     = 8,
  parameter int                   WDOG_LIMIT = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    stallreq,
  input  logic                  flush_req,
  input  logic [31:0]           flush_pc,
  output logic [NUM_STAGES:0]   stall,
  output logic                  flush,
  output logic [31:0]           new_pc,
  output logic                  new_pc_valid,
  output logic [WDOG_W-1:0]     stall_run,
  output logic                  wdog_timeout
);

  localparam int                FW        = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0]     FCNT_LOAD = FW'(FLUSH_CYC - 1);
  localparam logic [WDOG_W-1:0] RUN_MAX   = '1;
  localparam logic [WDOG_W-1:0] RUN_TRIP  = WDOG_W'(WDOG_LIMIT - 1);

  logic [FW-1:0]       fcnt_r;
  logic [31:0]         pc_q_r;
  logic [WDOG_W-1:0]   stall_run_r;
  logic                wdog_r;
  logic [NUM_STAGES:0] stall_req_s;
  logic [NUM_STAGES:0] stall_s;
  logic                flush_s;

  // Merge requests: a source at stage s holds every stage from PC up to s.
  always_comb begin
    stall_req_s = '0;
    for (int k = 0; k <= NUM_STAGES; k++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        stall_req_s[k] = stall_req_s[k] |
                         (stallreq[r] & ({29'd0, REQ_STAGE[r*3 +: 3]} >= 32'(k)));
      end
    end
  end

  // Flush window and stall gating; a flush discards all held stages.
  always_comb begin
    flush_s = ~rst & (flush_req | (fcnt_r != '0));
    if (rst || flush_s) begin
      stall_s = '0;
    end else begin
      stall_s = stall_req_s;
    end
  end

  // Redirect and status outputs, all forced to zero while in reset.
  always_comb begin
    if (rst) begin
      new_pc       = 32'd0;
      new_pc_valid = 1'b0;
      stall_run    = '0;
      wdog_timeout = 1'b0;
    end else begin
      new_pc       = flush_req ? flush_pc : pc_q_r;
      new_pc_valid = flush_req;
      stall_run    = stall_run_r;
      wdog_timeout = wdog_r;
    end
  end

  assign stall = stall_s;
  assign flush = flush_s;

  // Flush counter, latched redirect target and stall-run watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_r      <= '0;
      pc_q_r      <= 32'd0;
      stall_run_r <= '0;
      wdog_r      <= 1'b0;
    end else begin
      // A new request restarts the window, so the latest target wins.
      if (flush_req) begin
        fcnt_r <= FCNT_LOAD;
        pc_q_r <= flush_pc;
      end else if (fcnt_r != '0) begin
        fcnt_r <= fcnt_r - FW'(1);
      end else begin
        fcnt_r <= fcnt_r;
      end
      if (stall_s[0]) begin
        if (stall_run_r != RUN_MAX) begin
          stall_run_r <= stall_run_r + WDOG_W'(1);
        end else begin
          stall_run_r <= stall_run_r;
        end
        if (stall_run_r == RUN_TRIP) begin
          wdog_r <= 1'b1;
        end else begin
          wdog_r <= wdog_r;
        end
      end else begin
        stall_run_r <= '0;
        wdog_r      <= wdog_r;
      end
    end
  end

endmodule
